// File: rtl/reset_conditioner_pkg.sv
// reset_conditioner_pkg: state encodings and sizing helper shared by the conditioner and its bench.
package reset_conditioner_pkg;

    typedef enum logic [2:0] {
        HOLD           = 3'd0,
        IDLE           = 3'd1,
        PRESS_FILTER   = 3'd2,
        PRESSED        = 3'd3,
        RELEASE_FILTER = 3'd4
    } rc_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level, with a selectable reset level.
module sync_2ff #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_LEVEL;
            r_sync <= RESET_LEVEL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/reset_conditioner.sv
// reset_conditioner: debounces a push-button and stretches it into a registered SoC reset
// with a minimum hold time, plus a one-cycle event pulse per accepted press.
module reset_conditioner
    import reset_conditioner_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES     = 270000,
    parameter int   RESET_HOLD_CYCLES   = 2700,
    parameter logic BUTTON_ACTIVE_LEVEL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic soc_reset,
    output logic reset_event
);
    localparam int CW = $clog2(max2(DEBOUNCE_CYCLES, RESET_HOLD_CYCLES) + 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || RESET_HOLD_CYCLES < 2) begin : g_bad_params
        $error("reset_conditioner: DEBOUNCE_CYCLES and RESET_HOLD_CYCLES must both be >= 2");
    end

    logic      w_sync;
    logic      w_pressed;
    rc_state_t r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic      r_soc;
    logic      r_event;

    sync_2ff #(.RESET_LEVEL(~BUTTON_ACTIVE_LEVEL)) u_sync (
        .i_clk (clock),
        .i_rst (reset),
        .i_d   (button_in),
        .o_q   (w_sync)
    );

    assign w_pressed = (w_sync == BUTTON_ACTIVE_LEVEL);

    // Every terminal count forces a state change, so the counter never wraps.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_next     = w_pressed ? PRESSED : IDLE;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (w_pressed) begin
                    w_next     = PRESS_FILTER;
                    w_cnt_next = '0;
                end
            end
            PRESS_FILTER: begin
                if (!w_pressed) begin
                    w_next = IDLE;
                end else if (r_cnt == DEB_LAST) begin
                    w_next     = PRESSED;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!w_pressed) begin
                    w_next     = RELEASE_FILTER;
                    w_cnt_next = '0;
                end
            end
            RELEASE_FILTER: begin
                if (w_pressed) begin
                    w_next = PRESSED;
                end else if (r_cnt == DEB_LAST) begin
                    w_next     = HOLD;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_next     = HOLD;
                w_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= HOLD;
            r_cnt   <= '0;
            r_soc   <= 1'b1;
            r_event <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_soc   <= (w_next == HOLD) || (w_next == PRESSED) || (w_next == RELEASE_FILTER);
            r_event <= (r_state == PRESS_FILTER) && (w_next == PRESSED);
        end
    end

    assign soc_reset   = r_soc;
    assign reset_event = r_event;
endmodule

// File: doc/reset_conditioner.md
RESET_CONDITIONER -- requirements
Module: reset_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 270000, meaning stable-level cycles before a button edge is accepted (10 ms at 27 MHz).
REQ-002 SHALL have parameter RESET_HOLD_CYCLES, default 2700, meaning the minimum cycles soc_reset stays high after block reset or button release.
REQ-003 SHALL have parameter BUTTON_ACTIVE_LEVEL, default 1'b1, meaning the raw button level that counts as pressed.
REQ-004 SHALL have port clock, input, 1, meaning the single system clock.
REQ-005 SHALL have port reset, input, 1, meaning the block reset, synchronous to clock and active-high.
REQ-006 SHALL have port button_in, input, 1, meaning the raw asynchronous push-button level.
REQ-007 SHALL have port soc_reset, output, 1, meaning the registered active-high reset driven to the downstream SoC reset input.
REQ-008 SHALL have port reset_event, output, 1, meaning a one-cycle pulse marking each accepted button press.

Function
REQ-009 SHALL pass button_in through a 2-FF synchronizer; pressed = (synchronized level == BUTTON_ACTIVE_LEVEL).
REQ-010 SHALL implement states HOLD, IDLE, PRESS_FILTER, PRESSED, RELEASE_FILTER with a single shared cycle counter.
REQ-011 HOLD: counter increments every cycle; at counter == RESET_HOLD_CYCLES-1 the state goes to PRESSED if pressed, else to IDLE; counter clears.
REQ-012 IDLE: when pressed, the state goes to PRESS_FILTER and counter clears.
REQ-013 PRESS_FILTER: when not pressed, the state returns to IDLE; otherwise counter increments; at counter == DEBOUNCE_CYCLES-1 the state goes to PRESSED.
REQ-014 PRESSED: when not pressed, the state goes to RELEASE_FILTER and counter clears.
REQ-015 RELEASE_FILTER: when pressed, the state returns to PRESSED; otherwise counter increments; at counter == DEBOUNCE_CYCLES-1 the state goes to HOLD and counter clears.
REQ-016 soc_reset SHALL be registered, updated on the same edge as the state, high exactly when the state is HOLD, PRESSED or RELEASE_FILTER.
REQ-017 reset_event SHALL be registered and high for exactly one cycle after each PRESS_FILTER->PRESSED transition; it is never asserted for HOLD->PRESSED.
REQ-018 Press latency SHALL be exact: if button_in reaches the active level before edge k and holds, soc_reset is first high after edge k+2+DEBOUNCE_CYCLES.
REQ-019 Release latency SHALL be exact: soc_reset falls after 2+DEBOUNCE_CYCLES+RESET_HOLD_CYCLES edges of stable release.
REQ-020 Counter width SHALL be $clog2(max(DEBOUNCE_CYCLES,RESET_HOLD_CYCLES)+1); the counter never wraps, since every terminal count forces a transition.
REQ-021 Both parameters SHALL be >= 2; an elaboration-time check rejects smaller values.

Reset
REQ-022 When reset is high at an edge, the block SHALL set state HOLD, counter 0, soc_reset 1, reset_event 0, and both synchronizer flops to the inactive level, from any state including mid-filter.
REQ-023 Reset asserted for multiple cycles SHALL hold all of the above; HOLD counting starts on the first edge with reset low.

Structure
REQ-024 State encodings (3-bit) SHALL live in shared package reset_conditioner_pkg for reuse by the bench.
REQ-025 The synchronizer SHALL be a separate sub-module sync_2ff (parameterized reset level), reusable for uart_rx.
REQ-026 Total RTL SHALL be roughly 120-200 lines; the FSM and counter live in reset_conditioner.

Verification (DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=8, BUTTON_ACTIVE_LEVEL=1)
REQ-027 Block reset released, button low -> soc_reset high for exactly 8 cycles, then low; reset_event stays 0.
REQ-028 Button high 3 cycles then low -> soc_reset never rises; reset_event stays 0.
REQ-029 Button rises before edge k and holds -> soc_reset high after edge k+6; reset_event pulses exactly one cycle.
REQ-030 While PRESSED, button bounces low 2 cycles and high, then releases stably -> soc_reset stays high throughout; it falls 14 edges after the stable release.
REQ-031 Reset asserted mid-PRESS_FILTER -> soc_reset 1 after that edge; state HOLD; counting restarts.
REQ-032 Button held high from reset release -> HOLD exits to PRESSED; soc_reset never drops; no reset_event.
